// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Purpose  : Shared constants and helpers for the iterative RV32M
//            multiply/divide unit: funct3 opcodes, FSM state encoding and
//            operand signedness decode.
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  // M-extension funct3 opcodes
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PREP = 2'd1;
  localparam logic [1:0] ST_CALC = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // rs1 is interpreted as two's complement
  function automatic logic is_signed_a(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is interpreted as two's complement
  function automatic logic is_signed_b(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_signfix.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_signfix
// Purpose  : Combinational conditional negation plus half-word select.
//            Wide mode negates the whole 2*XLEN value (product fixup);
//            split mode negates each XLEN half on its own (operand
//            magnitudes, quotient/remainder fixup).
// Ports    : i_val    - {hi, lo} input value
//            i_split  - 1: halves negated independently, 0: whole value
//            i_neg_hi - negate high half (split mode)
//            i_neg_lo - negate low half (split) / whole value (wide)
//            i_sel_hi - o_word takes the high half when set
//            o_full   - full 2*XLEN result after negation
//            o_word   - selected XLEN half of o_full
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_signfix #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] i_val,
  input  logic              i_split,
  input  logic              i_neg_hi,
  input  logic              i_neg_lo,
  input  logic              i_sel_hi,
  output logic [2*XLEN-1:0] o_full,
  output logic [XLEN-1:0]   o_word
);

  logic [2*XLEN-1:0] w_wide;
  logic [XLEN-1:0]   w_hi;
  logic [XLEN-1:0]   w_lo;

  assign w_wide = i_neg_lo ? -i_val : i_val;
  assign w_hi   = i_neg_hi ? -i_val[2*XLEN-1:XLEN] : i_val[2*XLEN-1:XLEN];
  assign w_lo   = i_neg_lo ? -i_val[XLEN-1:0]      : i_val[XLEN-1:0];

  assign o_full = i_split ? {w_hi, w_lo} : w_wide;
  assign o_word = i_sel_hi ? o_full[2*XLEN-1:XLEN] : o_full[XLEN-1:0];

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RV32M multiply/divide unit. One radix-2 step per
//            cycle; busy stays high from the sampling of start until the
//            cycle after done so the core can stall.
// Ports    : clk, rst       - clock, synchronous active-high reset
//            start          - request, sampled only in IDLE
//            funct3         - M-extension opcode
//            op_a, op_b     - rs1 / rs2 values
//            busy           - high in any state other than IDLE
//            done           - one-cycle pulse, result valid in this cycle
//            result         - result, held until the next completion
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [2:0]        r_f3;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic              r_neg;
  logic [2*XLEN-1:0] r_prod;
  logic [XLEN-1:0]   r_quot;
  logic [XLEN:0]     r_rem;
  logic [XLEN-1:0]   r_opb;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_result;

  logic              w_is_div;
  logic              w_is_rem;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic              w_fast;
  logic              w_sa_neg;
  logic              w_sb_neg;
  logic [2*XLEN-1:0] w_abs;
  logic [XLEN-1:0]   w_abs_sel_unused;
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN+1:0]   w_rem_sh;
  logic [XLEN+1:0]   w_rem_sub;
  logic              w_q_bit;
  logic [2*XLEN-1:0] w_fix_in;
  logic [2*XLEN-1:0] w_fix_full_unused;
  logic [XLEN-1:0]   w_fix_word;

  // --------------------------------------------------------------------------
  // Decode of the latched operation
  // --------------------------------------------------------------------------
  assign w_is_div   = r_f3[2];
  assign w_is_rem   = r_f3[2] & r_f3[1];
  assign w_div_zero = (r_b == '0);
  // Signed most-negative / -1 (DIV and REM only: funct3[0] clear)
  assign w_div_ovf  = w_is_div & ~r_f3[0] &
                      (r_a == {1'b1, {(XLEN-1){1'b0}}}) & (r_b == '1);
  assign w_fast     = w_is_div & (w_div_zero | w_div_ovf);
  assign w_sa_neg   = is_signed_a(r_f3) & r_a[XLEN-1];
  assign w_sb_neg   = is_signed_b(r_f3) & r_b[XLEN-1];

  // Operand magnitudes: {|a|, |b|}
  muldiv_signfix #(.XLEN(XLEN)) u_abs (
    .i_val    ({r_a, r_b}),
    .i_split  (1'b1),
    .i_neg_hi (w_sa_neg),
    .i_neg_lo (w_sb_neg),
    .i_sel_hi (1'b0),
    .o_full   (w_abs),
    .o_word   (w_abs_sel_unused)
  );

  // Shift-add step: r_prod low half holds the remaining multiplier bits
  assign w_mul_sum = {1'b0, r_prod[2*XLEN-1:XLEN]} +
                     {1'b0, (r_prod[0] ? r_opb : {XLEN{1'b0}})};

  // Restoring step: the dividend is shifted out of r_quot MSB-first while
  // quotient bits shift in at the bottom. Extra top bit of the subtraction
  // is the borrow.
  assign w_rem_sh  = {r_rem, r_quot[XLEN-1]};
  assign w_rem_sub = w_rem_sh - {2'b00, r_opb};
  assign w_q_bit   = ~w_rem_sub[XLEN+1];

  // Result fixup. Divide results go through split mode so only the
  // selected quotient or remainder half is negated.
  assign w_fix_in = w_is_div ? {r_rem[XLEN-1:0], r_quot} : r_prod;

  muldiv_signfix #(.XLEN(XLEN)) u_fix (
    .i_val    (w_fix_in),
    .i_split  (w_is_div),
    .i_neg_hi (r_neg),
    .i_neg_lo (r_neg),
    .i_sel_hi (w_is_div ? w_is_rem : (r_f3 != F3_MUL)),
    .o_full   (w_fix_full_unused),
    .o_word   (w_fix_word)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_PREP;
      ST_PREP: w_next = w_fast ? ST_DONE : ST_CALC;
      ST_CALC: if (r_cnt == CNT_W'(XLEN - 1)) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // FSM: outputs. The fixed-up value is forwarded during DONE so done and
  // a valid result coincide; r_result captures it for the hold period.
  always_comb begin
    busy   = (r_state != ST_IDLE);
    done   = (r_state == ST_DONE);
    result = (r_state == ST_DONE) ? w_fix_word : r_result;
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_f3     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_neg    <= 1'b0;
      r_prod   <= '0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_opb    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_f3 <= funct3;
            r_a  <= op_a;
            r_b  <= op_b;
          end
        end
        ST_PREP: begin
          r_cnt  <= '0;
          r_prod <= {{XLEN{1'b0}}, w_abs[2*XLEN-1:XLEN]};
          r_quot <= w_abs[2*XLEN-1:XLEN];
          r_rem  <= '0;
          r_opb  <= w_abs[XLEN-1:0];
          r_neg  <= w_is_rem ? w_sa_neg : (w_sa_neg ^ w_sb_neg);
          // Fast paths preload the final answer with no sign fixup
          if (w_fast) begin
            r_neg  <= 1'b0;
            r_quot <= w_div_zero ? {XLEN{1'b1}} : r_a;
            r_rem  <= w_div_zero ? {1'b0, r_a} : '0;
          end
        end
        ST_CALC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_is_div) begin
            r_rem  <= w_q_bit ? w_rem_sub[XLEN:0] : w_rem_sh[XLEN:0];
            r_quot <= {r_quot[XLEN-2:0], w_q_bit};
          end else begin
            r_prod <= {w_mul_sum, r_prod[XLEN-1:1]};
          end
        end
        ST_DONE: begin
          r_result <= w_fix_word;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
